// File: rtl/aes_inv_key_expand.sv
`timescale 1ns/1ps
// aes_inv_key_expand
// -----------------------------------------------------------------------------
// Reverse-direction AES-128 key schedule. Loaded with the round-10 key, it
// regenerates round keys 10, 9, ..., 0 in the order the inverse cipher uses
// them, so the decryption datapath needs no stored copy of the expanded key.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     load key_in and begin a sequence (sampled only while idle)
//   key_in    round-10 key, word w40 in [127:96], w43 in [31:0]
//   rk_ready  consumer accepts rk_out this cycle
//   rk_valid  rk_out / rk_idx are valid
//   rk_out    current round key, same word ordering as key_in
//   rk_idx    round number of rk_out (10 down to 0)
//   busy      high while a sequence is running
//   done      one-cycle pulse after round key 0 has been transferred
//
// Handshake: a round key moves to the consumer on every rising edge where
// rk_valid and rk_ready are both high. While rk_valid is high and rk_ready is
// low, rk_out and rk_idx hold their values; the consumer may drop or raise
// rk_ready on any cycle.
// -----------------------------------------------------------------------------

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine
// transform. The inverse is formed as a^254 with a fixed square/multiply
// chain, which maps 0 to 0 as the S-box requires.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] a2, a3, a12, a15, a240, inv;

    always_comb begin
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));      // (a^3)^4
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(gf_mul(a15, a15), gf_mul(a15, a15));   // (a^15)^4 = a^60
        a240 = gf_mul(gf_mul(a240, a240), gf_mul(a240, a240)); // (a^60)^4 = a^240
        inv  = gf_mul(gf_mul(a240, a12), a2);                // a^(240+12+2)
        for (int i = 0; i < 8; i++) begin
            y[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                 ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        end
        y = y ^ 8'h63;
    end
endmodule

module aes_inv_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q, state_nx;
    logic [127:0] key_q, key_nx;
    logic [3:0]   idx_q, idx_nx;
    logic [7:0]   rcon_q, rcon_nx;
    logic         done_q, done_nx;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  rot_n3, sub_n3;
    logic [127:0] prev_key;
    logic [7:0]   rcon_prev;
    logic         xfer;

    // Undo one forward expansion step. The last three words of the earlier
    // round are pairwise XORs of the current ones; the first word needs the
    // earlier round's w3 (= n3) pushed through RotWord/SubWord/Rcon again.
    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign n3     = w3 ^ w2;
    assign n2     = w2 ^ w1;
    assign n1     = w1 ^ w0;
    assign rot_n3 = {n3[23:0], n3[31:24]};

    aes_sbox u_sbox0 (.a(rot_n3[31:24]), .y(sub_n3[31:24]));
    aes_sbox u_sbox1 (.a(rot_n3[23:16]), .y(sub_n3[23:16]));
    aes_sbox u_sbox2 (.a(rot_n3[15:8]),  .y(sub_n3[15:8]));
    aes_sbox u_sbox3 (.a(rot_n3[7:0]),   .y(sub_n3[7:0]));

    assign n0       = w0 ^ sub_n3 ^ {rcon_q, 24'h000000};
    assign prev_key = {n0, n1, n2, n3};

    // Inverse of xtime: walks Rcon backwards 36, 1b, 80, 40, ..., 01.
    assign rcon_prev = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80)
                                 : (rcon_q >> 1);

    assign rk_valid = (state_q == RUN);
    assign xfer     = rk_valid && rk_ready;

    always_comb begin
        state_nx = state_q;
        key_nx   = key_q;
        idx_nx   = idx_q;
        rcon_nx  = rcon_q;
        done_nx  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_nx   = key_in;
                    idx_nx   = 4'd10;
                    rcon_nx  = 8'h36;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (idx_q == 4'd0) begin
                        // Round key 0 stays visible on rk_out after the run.
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        key_nx  = prev_key;
                        idx_nx  = idx_q - 4'd1;
                        rcon_nx = rcon_prev;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            key_q   <= key_nx;
            idx_q   <= idx_nx;
            rcon_q  <= rcon_nx;
            done_q  <= done_nx;
        end
    end

    assign rk_out = key_q;
    assign rk_idx = idx_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;
endmodule

// File: tb/tb_aes_inv_key_expand.sv
`timescale 1ns/1ps
module tb_aes_inv_key_expand;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    localparam logic [127:0] FIPS_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_inv_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .rk_out(rk_out), .rk_idx(rk_idx), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_rk [0:10];

    logic [127:0] got_q [$];
    logic [3:0]   gidx_q [$];
    logic [127:0] exp_q [$];
    int           done_cnt, done_cycle, stall_err;

    // Driver/monitor: runs one sequence after start was driven, records every
    // transferred round key, counts done pulses and stall instability.
    task automatic collect(input bit rand_ready, input bit hook_en, input bit b2b,
                           input logic [127:0] b2b_key);
        bit           prev_stall = 1'b0;
        bit           hooked = 1'b0;
        logic [127:0] prev_rk = '0;
        logic [3:0]   prev_idx = '0;
        got_q.delete();
        gidx_q.delete();
        done_cnt = 0;
        done_cycle = -1;
        stall_err = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall && (rk_out !== prev_rk || rk_idx !== prev_idx)) stall_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = i;
                if (b2b) begin
                    start  = 1'b1;
                    key_in = b2b_key;
                    return;
                end
            end
            if (hook_en && !hooked && rk_valid === 1'b1 && rk_idx == 4'd6) begin
                start  = 1'b1;
                key_in = OTHER_KEY;
                hooked = 1'b1;
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid === 1'b1 && rk_ready) begin
                got_q.push_back(rk_out);
                gidx_q.push_back(rk_idx);
            end
            prev_stall = (rk_valid === 1'b1) && !rk_ready;
            prev_rk    = rk_out;
            prev_idx   = rk_idx;
            if (done_cycle > 0 && i >= done_cycle + 3) return;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({rk_valid, busy, done, rk_idx, rk_out} !== '0)
            $display("FAIL reset_during: got v=%b b=%b d=%b idx=%0d rk=%h, expected all zero",
                     rk_valid, busy, done, rk_idx, rk_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rk_valid, busy, done, rk_idx, rk_out} !== '0)
            $display("FAIL reset_after: got v=%b b=%b d=%b idx=%0d rk=%h, expected all zero",
                     rk_valid, busy, done, rk_idx, rk_out);
        else n_pass++;
    endtask

    task automatic test_fips();
        @(negedge clk);
        start = 1'b1;
        key_in = FIPS_KEY;
        collect(1'b0, 1'b0, 1'b0, '0);
        exp_q.delete();
        for (int k = 10; k >= 0; k--) exp_q.push_back(fips_rk[k]);
        n_checks++;
        if (got_q.size() != 11) $display("FAIL fips_count: got %0d expected 11", got_q.size());
        else n_pass++;
        for (int k = 0; k < 11 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k] || gidx_q[k] !== 4'(10 - k))
                $display("FAIL fips_rk%0d: got idx=%0d %h expected idx=%0d %h",
                         10 - k, gidx_q[k], got_q[k], 10 - k, exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt != 1 || done_cycle != 12)
            $display("FAIL fips_done: got count=%0d cycle=%0d expected count=1 cycle=12",
                     done_cnt, done_cycle);
        else n_pass++;
        n_checks++;
        if (rk_out !== fips_rk[0] || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL fips_hold: got rk=%h idx=%0d v=%b b=%b expected %h idx=0 v=0 b=0",
                     rk_out, rk_idx, rk_valid, busy, fips_rk[0]);
        else n_pass++;
    endtask

    task automatic test_zero_key();
        @(negedge clk);
        start = 1'b1;
        key_in = ZERO_KEY;
        collect(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (got_q.size() != 11) $display("FAIL zero_count: got %0d expected 11", got_q.size());
        else n_pass++;
        for (int k = 0; k < 11 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== zero_rk[10 - k] || gidx_q[k] !== 4'(10 - k))
                $display("FAIL zero_rk%0d: got idx=%0d %h expected %h",
                         10 - k, gidx_q[k], got_q[k], zero_rk[10 - k]);
            else n_pass++;
        end
        n_checks++;
        if (rk_out !== 128'h0 || done_cnt != 1)
            $display("FAIL zero_final: got rk=%h done_cnt=%0d expected 0 and 1", rk_out, done_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        start = 1'b1;
        key_in = FIPS_KEY;
        collect(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if (stall_err != 0) $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_err);
        else n_pass++;
        n_checks++;
        if (got_q.size() != 11 || done_cnt != 1)
            $display("FAIL bp_count: got xfers=%0d dones=%0d expected 11 and 1", got_q.size(), done_cnt);
        else n_pass++;
        for (int k = 0; k < 11 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== fips_rk[10 - k] || gidx_q[k] !== 4'(10 - k))
                $display("FAIL bp_rk%0d: got idx=%0d %h expected %h",
                         10 - k, gidx_q[k], got_q[k], fips_rk[10 - k]);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        start = 1'b1;
        key_in = FIPS_KEY;
        collect(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (got_q.size() != 11 || done_cnt != 1 || done_cycle != 12)
            $display("FAIL ign_count: got xfers=%0d dones=%0d cycle=%0d expected 11 1 12",
                     got_q.size(), done_cnt, done_cycle);
        else n_pass++;
        for (int k = 0; k < 11 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== fips_rk[10 - k] || gidx_q[k] !== 4'(10 - k))
                $display("FAIL ign_rk%0d: got idx=%0d %h expected %h",
                         10 - k, gidx_q[k], got_q[k], fips_rk[10 - k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        bit hit = 1'b0;
        bit bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        key_in = FIPS_KEY;
        rk_ready = 1'b1;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rk_valid === 1'b1 && rk_idx == 4'd4) hit = 1'b1;
        end
        n_checks++;
        if (!hit) $display("FAIL rstmid_reach: got no idx 4 within 20 cycles, expected idx 4");
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rk_valid, busy, done, rk_idx, rk_out} !== '0)
            $display("FAIL rstmid_async: got v=%b b=%b d=%b idx=%0d rk=%h expected all zero",
                     rk_valid, busy, done, rk_idx, rk_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL rstmid_quiet: got done/busy/valid activity after reset expected none");
        else n_pass++;
        start = 1'b1;
        key_in = FIPS_KEY;
        collect(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (got_q.size() != 11 || done_cnt != 1)
            $display("FAIL rstmid_count: got xfers=%0d dones=%0d expected 11 and 1", got_q.size(), done_cnt);
        else n_pass++;
        for (int k = 0; k < 11 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== fips_rk[10 - k] || gidx_q[k] !== 4'(10 - k))
                $display("FAIL rstmid_rk%0d: got idx=%0d %h expected %h",
                         10 - k, gidx_q[k], got_q[k], fips_rk[10 - k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1;
        key_in = FIPS_KEY;
        collect(1'b0, 1'b0, 1'b1, ZERO_KEY);
        n_checks++;
        if (got_q.size() != 11 || done_cycle != 12 || got_q[got_q.size() - 1] !== fips_rk[0])
            $display("FAIL b2b_first: got xfers=%0d cycle=%0d expected 11 xfers done cycle 12",
                     got_q.size(), done_cycle);
        else n_pass++;
        collect(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (got_q.size() != 11 || done_cnt != 1 || done_cycle != 12)
            $display("FAIL b2b_second: got xfers=%0d dones=%0d cycle=%0d expected 11 1 12",
                     got_q.size(), done_cnt, done_cycle);
        else n_pass++;
        for (int k = 0; k < 11 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== zero_rk[10 - k] || gidx_q[k] !== 4'(10 - k))
                $display("FAIL b2b_rk%0d: got idx=%0d %h expected %h",
                         10 - k, gidx_q[k], got_q[k], zero_rk[10 - k]);
            else n_pass++;
        end
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = FIPS_KEY;
        zero_rk[0]  = 128'h00000000000000000000000000000000;
        zero_rk[1]  = 128'h62636363626363636263636362636363;
        zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        zero_rk[10] = ZERO_KEY;

        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
